// File: rtl/ula_pkg.sv
// Shared constants and enums for the 2-bit ULA and its built-in self-test sequencer.
package ula_pkg;

  localparam int NBITS_OPER   = 2;
  localparam int NBITS_SELECT = 3;
  localparam int NBITS_RESULT = 2;
  localparam int NBITS_VEC    = NBITS_SELECT + 2 * NBITS_OPER;

  typedef enum logic [NBITS_SELECT-1:0] {
    AND  = 3'b000,
    OR   = 3'b001,
    ADD  = 3'b010,
    ZERO = 3'b011,
    ANDN = 3'b100,
    ORN  = 3'b101,
    SUB  = 3'b110,
    SLT  = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } bist_state_t;

endpackage

// File: rtl/ula_ref_model.sv
// Combinational golden model of the ULA: unsigned operands, results truncated
// to NBITS_RESULT.
module ula_ref_model
  import ula_pkg::*;
(
  input  logic [NBITS_SELECT-1:0] i_f,
  input  logic [NBITS_OPER-1:0]   i_a,
  input  logic [NBITS_OPER-1:0]   i_b,
  output logic [NBITS_RESULT-1:0] o_y
);

  ula_op_t w_op;

  assign w_op = ula_op_t'(i_f);

  always_comb begin
    o_y = '0;
    case (w_op)
      AND:  o_y = i_a & i_b;
      OR:   o_y = i_a | i_b;
      ADD:  o_y = i_a + i_b;
      ZERO: o_y = '0;
      ANDN: o_y = i_a & ~i_b;
      ORN:  o_y = i_a | ~i_b;
      SUB:  o_y = i_a - i_b;
      SLT:  o_y[0] = (i_a < i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/ula_bist.sv
// Self-test sequencer: sweeps all {F,A,B} vectors into the ULA and checks Y.
// Build option ULA_BIST_STOP_ON_FAIL_EN halts the sweep at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | current vector on alu_*, ULA settling
// SAMPLE | alu_y compared against the golden model
// DONE   | results valid; start re-launches a sweep
module ula_bist
  import ula_pkg::*;
#(
  parameter int NBITS_ERR = 8
)
(
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic                    start,
  output logic [NBITS_SELECT-1:0] alu_f,
  output logic [NBITS_OPER-1:0]   alu_a,
  output logic [NBITS_OPER-1:0]   alu_b,
  input  logic [NBITS_RESULT-1:0] alu_y,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NBITS_ERR-1:0]    err_count,
  output logic [NBITS_VEC-1:0]    fail_vec
);

  bist_state_t r_state;
  bist_state_t w_state_nxt;

  logic [NBITS_VEC-1:0]    r_idx;
  logic [NBITS_ERR-1:0]    r_err;
  logic [NBITS_VEC-1:0]    r_fail_vec;
  logic [NBITS_RESULT-1:0] w_y_exp;
  logic                    w_mismatch;
  logic                    w_last;
  logic                    w_launch;

  ula_ref_model u_ref (
    .i_f (r_idx[NBITS_VEC-1 -: NBITS_SELECT]),
    .i_a (r_idx[2*NBITS_OPER-1 -: NBITS_OPER]),
    .i_b (r_idx[NBITS_OPER-1:0]),
    .o_y (w_y_exp)
  );

  assign w_mismatch = (r_state == SAMPLE) && (alu_y != w_y_exp);
  assign w_last     = (r_idx == '1);
  assign w_launch   = start && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = DRIVE;
      DRIVE:  w_state_nxt = SAMPLE;
      SAMPLE: begin
`ifdef ULA_BIST_STOP_ON_FAIL_EN
        if (w_mismatch || w_last) w_state_nxt = DONE;
        else                      w_state_nxt = DRIVE;
`else
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = DRIVE;
`endif
      end
      DONE:   if (start) w_state_nxt = DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The index only advances on SAMPLE->DRIVE, so in DONE the operands still
  // show the last vector driven (the failing one when stopping on a fail).
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_err      <= '0;
      r_fail_vec <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_idx      <= '0;
        r_err      <= '0;
        r_fail_vec <= '0;
      end else if (r_state == SAMPLE) begin
        if (w_mismatch) begin
          if (r_err != '1) r_err <= r_err + 1'b1;
          if (r_err == '0) r_fail_vec <= r_idx;
        end
        if (w_state_nxt == DRIVE) r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign alu_f     = r_idx[NBITS_VEC-1 -: NBITS_SELECT];
  assign alu_a     = r_idx[2*NBITS_OPER-1 -: NBITS_OPER];
  assign alu_b     = r_idx[NBITS_OPER-1:0];
  assign busy      = (r_state == DRIVE) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign pass      = (r_state == DONE) && (r_err == '0);
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_ula_bist.sv
// Directed bench for ula_bist: a behavioural ULA with selectable faults feeds
// alu_y; expected counts and first-fail vectors are hand-computed.
module tb_ula_bist;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] alu_f;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [1:0] alu_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [6:0] fail_vec;

  int         fault_mode = 0;
  logic [1:0] y_good;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc;

  ula_bist dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .start     (start),
    .alu_f     (alu_f),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk_2 = ~clk_2;

  // 0: correct ULA, 1: Y stuck at 0, 2: SLT inverted, 3: ADD returns A|B
  always_comb begin
    y_good = 2'b00;
    case (alu_f)
      3'd0: y_good = alu_a & alu_b;
      3'd1: y_good = alu_a | alu_b;
      3'd2: y_good = 2'((int'(alu_a) + int'(alu_b)) % 4);
      3'd3: y_good = 2'b00;
      3'd4: y_good = alu_a & ~alu_b;
      3'd5: y_good = alu_a | ~alu_b;
      3'd6: y_good = 2'((int'(alu_a) - int'(alu_b) + 4) % 4);
      3'd7: y_good = (alu_a < alu_b) ? 2'd1 : 2'd0;
      default: y_good = 2'b00;
    endcase
    alu_y = y_good;
    case (fault_mode)
      1: alu_y = 2'b00;
      2: if (alu_f == 3'd7) alu_y = y_good ^ 2'd1;
      3: if (alu_f == 3'd2) alu_y = alu_a | alu_b;
      default: alu_y = y_good;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start (or hold it if keep_start), then wait for done within max_cyc edges.
  task automatic run_sweep(input int mode, input bit keep_start, input int max_cyc, output int n_cyc);
    fault_mode = mode;
    @(negedge clk_2);
    start = 1'b1;
    @(posedge clk_2); #1;
    chk("launch_busy", busy, 1);
    chk("launch_vec0", {alu_f, alu_a, alu_b}, 0);
    if (!keep_start) begin
      @(negedge clk_2);
      start = 1'b0;
    end
    n_cyc = 0;
    while (!done && n_cyc < max_cyc) begin
      @(posedge clk_2); #1;
      n_cyc++;
      if (n_cyc == 2 || n_cyc == 3) chk("vec1_held", {alu_f, alu_a, alu_b}, 1);
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk_2);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_failvec", fail_vec, 0);
    chk("rst_vec", {alu_f, alu_a, alu_b}, 0);

    // reset and start together: reset wins
    @(negedge clk_2);
    start = 1'b1;
    @(posedge clk_2); #1;
    chk("rst_start_busy", busy, 0);
    @(negedge clk_2);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk_2);
    #1;
    chk("idle_no_start", busy, 0);

    // correct ULA
    run_sweep(0, 1'b0, 400, cyc);
    chk("ok_cycles", cyc, 256);
    chk("ok_busy", busy, 0);
    chk("ok_pass", pass, 1);
    chk("ok_err", err_count, 0);
    repeat (5) @(posedge clk_2);
    #1;
    chk("ok_done_hold", done, 1);
    chk("ok_pass_hold", pass, 1);

    // Y stuck at 0: 74 vectors have nonzero golden result, first is AND 1,1
    run_sweep(1, 1'b0, 400, cyc);
`ifdef ULA_BIST_STOP_ON_FAIL_EN
    chk("stuck_cycles", cyc, 12);
    chk("stuck_err", err_count, 1);
`else
    chk("stuck_cycles", cyc, 256);
    chk("stuck_err", err_count, 74);
`endif
    chk("stuck_failvec", fail_vec, 7'b000_01_01);
    chk("stuck_pass", pass, 0);

    // SLT inverted: all 16 SLT vectors mismatch, first is 111_00_00
    run_sweep(2, 1'b0, 400, cyc);
`ifdef ULA_BIST_STOP_ON_FAIL_EN
    chk("slt_err", err_count, 1);
`else
    chk("slt_err", err_count, 16);
`endif
    chk("slt_failvec", fail_vec, 7'b111_00_00);
    chk("slt_pass", pass, 0);

    // ADD returns A|B: differs on the 7 carrying operand pairs, first is 010_01_01
    run_sweep(3, 1'b0, 400, cyc);
`ifdef ULA_BIST_STOP_ON_FAIL_EN
    chk("add_cycles", cyc, 76);
    chk("add_err", err_count, 1);
    chk("add_stop_f", alu_f, 2);
    chk("add_stop_a", alu_a, 1);
    chk("add_stop_b", alu_b, 1);
`else
    chk("add_err", err_count, 7);
`endif
    chk("add_failvec", fail_vec, 7'b010_01_01);
    chk("add_done", done, 1);

    // reset mid-sweep with errors already accumulated
    fault_mode = 1;
    @(negedge clk_2);
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    repeat (100) @(posedge clk_2);
    @(negedge clk_2);
    reset = 1'b1;
    @(posedge clk_2); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_failvec", fail_vec, 0);
    chk("mid_rst_vec", {alu_f, alu_a, alu_b}, 0);
    @(negedge clk_2);
    reset = 1'b0;
    repeat (3) @(posedge clk_2);
    #1;
    chk("mid_rst_idle", busy | done, 0);
    run_sweep(0, 1'b0, 400, cyc);
    chk("fresh_cycles", cyc, 256);
    chk("fresh_pass", pass, 1);

    // start held high: no restart while busy, immediate restart from DONE
    run_sweep(1, 1'b1, 400, cyc);
`ifdef ULA_BIST_STOP_ON_FAIL_EN
    chk("held_cycles", cyc, 12);
    chk("held_err", err_count, 1);
`else
    chk("held_cycles", cyc, 256);
    chk("held_err", err_count, 74);
`endif
    @(posedge clk_2); #1;
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_failvec", fail_vec, 0);
    chk("restart_pass", pass, 0);
    @(negedge clk_2);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
